// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous flagged FIFO: sizing helpers and
// a status record used by scoreboards and status registers.
package fifo_pkg;

  // Widest occupancy count a status record can carry.
  localparam int STATUS_CNT_W = 16;

  // Number of address bits needed to index DEPTH entries.
  function automatic int clog2_depth(input int depth);
    int r;
    r = 0;
    while ((1 << r) < depth) r++;
    return r;
  endfunction

  // Pointers carry one extra wrap bit beyond the memory address.
  function automatic int ptr_width(input int depth);
    return clog2_depth(depth) + 1;
  endfunction

  typedef struct packed {
    logic [STATUS_CNT_W-1:0] count;
    logic                    almost_full;
    logic                    almost_empty;
    logic                    overflow;
    logic                    underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_if.sv
// Write/read handshake bundle for the FIFO; both sides share one clock.
interface fifo_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_full;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_empty;
  logic [CNT_W-1:0]  count;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;
  logic              err_clr;

  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  wr_full, rd_data, rd_valid, rd_empty, count,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output wr_full, rd_data, rd_valid, rd_empty, count,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, registered read with enable.
// No reset on the array or read register so it maps onto block RAM.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = clog2_depth(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port and enabled, registered read port.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic clk,
  input  logic rst_n,
  fifo_if.slave bus
);

  localparam int ADDR_W = clog2_depth(DEPTH);
  localparam int PTR_W  = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0] FULL_V   = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AFULL_V  = PTR_W'(AFULL_TH);
  localparam logic [PTR_W-1:0] AEMPTY_V = PTR_W'(AEMPTY_TH);

  generate
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_flags: DEPTH must be a power of two and >= 4");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
      $error("sync_fifo_flags: AFULL_TH must lie in 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
      $error("sync_fifo_flags: AEMPTY_TH must lie in 0..DEPTH-1");
    end
  endgenerate

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_count;
  logic              r_rd_valid;
  logic              r_data_seen;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [DATA_W-1:0] w_mem_q;

  // Flags come only from the registered count, never from this cycle's requests.
  assign w_full   = (r_count == FULL_V);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = bus.wr_en & ~w_full;
  assign w_rd_acc = bus.rd_en & ~w_empty;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .i_wr_data (bus.wr_data),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .o_rd_data (w_mem_q)
  );

  // Pointer and occupancy bookkeeping; only accepted transfers move state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + PTR_W'(1);
        2'b01:   r_count <= r_count - PTR_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Read-valid strobe, plus a marker that the RAM read register holds real data.
  // The RAM register itself has no reset, so rd_data is forced to zero until
  // the first accepted read after reset; afterwards the RAM register holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid  <= 1'b0;
      r_data_seen <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_data_seen <= 1'b1;
    end
  end

  // Sticky error flags; a clear wins over a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.err_clr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.wr_en & w_full)  r_overflow  <= 1'b1;
      if (bus.rd_en & w_empty) r_underflow <= 1'b1;
    end
  end

  assign bus.wr_full      = w_full;
  assign bus.rd_empty     = w_empty;
  assign bus.count        = r_count;
  assign bus.almost_full  = (r_count >= AFULL_V);
  assign bus.almost_empty = (r_count <= AEMPTY_V);
  assign bus.rd_valid     = r_rd_valid;
  assign bus.rd_data      = r_data_seen ? w_mem_q : '0;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule
